// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // RAM-port activity: IDLE = nothing driven this cycle, ISSUE = access on mem_*.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Identifies which master owns a grant or an outstanding read.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } owner_t;

  // All-ones byte enable; wide enough for any DW, sliced to DW/8 where used.
  localparam logic [127:0] BE_ALL = '1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one master's request/response bus towards the data-memory arbiter.
// The master modport issues requests, the slave modport (arbiter side) answers with
// gnt, rvalid and rdata.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            req;
  logic            we;
  logic [DW/8-1:0] be;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select between the two eligible requesters.
// Build option DMEM_ARB_RR_EN: when defined, contention goes to the port that did
// not win last (pointer input present); when undefined, port 0 always wins.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] elig,
`ifdef DMEM_ARB_RR_EN
  input  owner_t     last,
`endif
  output logic       any,
  output owner_t     winner
);

  // Single requester wins outright; contention resolved by priority or pointer.
  always_comb begin
    any    = |elig;
    winner = PORT0;
    if (elig[0] && elig[1]) begin
`ifdef DMEM_ARB_RR_EN
      winner = (last == PORT0) ? PORT1 : PORT0;
`else
      winner = PORT0;
`endif
    end else if (elig[1]) begin
      winner = PORT1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data block RAM between the CPU load/store
// port (m0) and a second bus master (m1). The winning request is registered onto
// mem_*, the owner gets a one-cycle gnt, and a read returns rvalid one cycle later.
// Build option DMEM_ARB_RR_EN selects round-robin contention instead of fixed
// priority (port 0 wins).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  dmem_arbiter_if.slave   m0,
  dmem_arbiter_if.slave   m1,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;

  state_t          state_reg;
  logic [1:0]      gnt_reg;
  logic [1:0]      rvalid_reg;
  logic [AW-1:0]   mem_addr_reg;
  logic [BW-1:0]   mem_be_reg;
  logic            mem_we_reg;
  logic [DW-1:0]   mem_wdata_reg;
  logic            rd_pending_reg;
  owner_t          rd_owner_reg;
`ifdef DMEM_ARB_RR_EN
  owner_t          last_reg;
`endif

  logic [1:0]      elig;
  logic            any;
  owner_t          winner;
  logic            win_we;
  logic [BW-1:0]   win_be;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;

  // A master whose gnt is high this cycle is still showing the request just
  // accepted, so it is not eligible again until gnt drops.
  assign elig = {m1.req & ~gnt_reg[1], m0.req & ~gnt_reg[0]};

  dmem_arb_pick u_pick (
    .elig   (elig),
`ifdef DMEM_ARB_RR_EN
    .last   (last_reg),
`endif
    .any    (any),
    .winner (winner)
  );

  // Route the winning master's request fields towards the RAM-port registers.
  always_comb begin
    win_we    = m0.we;
    win_be    = m0.be;
    win_addr  = m0.addr;
    win_wdata = m0.wdata;
    if (winner == PORT1) begin
      win_we    = m1.we;
      win_be    = m1.be;
      win_addr  = m1.addr;
      win_wdata = m1.wdata;
    end
  end

  // Arbiter FSM: register the winner onto the RAM port, pulse gnt, and turn a
  // read issued last cycle into an rvalid pulse for its owner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      gnt_reg        <= '0;
      rvalid_reg     <= '0;
      mem_addr_reg   <= '0;
      mem_be_reg     <= '0;
      mem_we_reg     <= 1'b0;
      mem_wdata_reg  <= '0;
      rd_pending_reg <= 1'b0;
      rd_owner_reg   <= PORT0;
`ifdef DMEM_ARB_RR_EN
      last_reg       <= PORT0;
`endif
    end else begin
      // The RAM has sampled the read address by this edge; its data is valid now.
      rvalid_reg[0]  <= rd_pending_reg && (state_reg == ISSUE) && (rd_owner_reg == PORT0);
      rvalid_reg[1]  <= rd_pending_reg && (state_reg == ISSUE) && (rd_owner_reg == PORT1);
      gnt_reg[0]     <= any && (winner == PORT0);
      gnt_reg[1]     <= any && (winner == PORT1);
      rd_pending_reg <= 1'b0;
      if (any) begin
        state_reg     <= ISSUE;
        mem_addr_reg  <= win_addr;
        mem_we_reg    <= win_we;
        mem_be_reg    <= win_we ? win_be : BE_ALL[BW-1:0];
        mem_wdata_reg <= win_wdata;
        if (!win_we) begin
          rd_pending_reg <= 1'b1;
          rd_owner_reg   <= winner;
        end
`ifdef DMEM_ARB_RR_EN
        last_reg      <= winner;
`endif
      end else begin
        state_reg  <= IDLE;
        mem_we_reg <= 1'b0;
      end
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_be    = mem_be_reg;
  assign mem_we    = mem_we_reg;
  assign mem_wdata = mem_wdata_reg;

  assign m0.gnt    = gnt_reg[0];
  assign m1.gnt    = gnt_reg[1];
  assign m0.rvalid = rvalid_reg[0];
  assign m1.rvalid = rvalid_reg[1];
  // Both masters see the RAM output; only the owner's rvalid qualifies it.
  assign m0.rdata  = mem_rdata;
  assign m1.rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter. A predictor applies the
// arbitration rules to the sampled requests and queues the expected grant and
// read data; a monitor pops and compares whenever the DUT shows gnt or rvalid.
// Honours DMEM_ARB_RR_EN the same way the design does.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NW = 64;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_exp_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  gnt_exp_t    gnt_q[$];
  rd_exp_t     rd_q[$];
  int          gnt_log[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          overlap_cnt = 0;
  int          rvalid_cnt = 0;
  logic [31:0] last_rdata0 = '0;
  logic        ram_load = 1'b0;
  logic [31:0] ram [NW];

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'h55AA55AA;
    return 32'hA5000000 ^ (32'(i) * 32'h00010203);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle counter: value k after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous block RAM model: byte-masked write, registered read.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < NW; i++) ram[i] <= init_word(i);
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= ram[mem_addr[7:2]];
  end

  // Predictor: applies the arbitration rules to the requests sampled before each
  // edge and queues what the DUT must show after that edge.
  initial begin : predictor
    logic [31:0] ref_mem [NW];
    int          prev_w;
    bit          e0, e1;
    int          w;
    int          idx;
    gnt_exp_t    g;
    rd_exp_t     r;
`ifdef DMEM_ARB_RR_EN
    int          last;
    last = 0;
`endif
    prev_w = -1;
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_w = -1;
`ifdef DMEM_ARB_RR_EN
        last = 0;
`endif
        continue;
      end
      // A port granted at the previous edge is showing gnt now and is not eligible.
      e0 = m0_if.req && (prev_w != 0);
      e1 = m1_if.req && (prev_w != 1);
      if (e0 || e1) begin
        if (e0 && e1) begin
`ifdef DMEM_ARB_RR_EN
          w = 1 - last;
`else
          w = 0;
`endif
        end else begin
          w = e0 ? 0 : 1;
        end
`ifdef DMEM_ARB_RR_EN
        last = w;
`endif
        g.port  = w;
        g.we    = (w == 1) ? m1_if.we : m0_if.we;
        g.be    = (w == 1) ? m1_if.be : m0_if.be;
        g.addr  = (w == 1) ? m1_if.addr : m0_if.addr;
        g.wdata = (w == 1) ? m1_if.wdata : m0_if.wdata;
        gnt_q.push_back(g);
        idx = int'(g.addr[7:2]);
        if (g.we) begin
          for (int b = 0; b < 4; b++)
            if (g.be[b]) ref_mem[idx][8*b +: 8] = g.wdata[8*b +: 8];
        end else begin
          r.port = w;
          r.data = ref_mem[idx];
          r.due  = cyc + 2;
          rd_q.push_back(r);
        end
        prev_w = w;
      end else begin
        prev_w = -1;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin : monitor
    gnt_exp_t e;
    rd_exp_t  r;
    bit       exp_v;
    int       ep;
    forever begin
      @(posedge clk);
      #2;
      if (!resetn) begin
        gnt_q.delete();
        rd_q.delete();
        continue;
      end
      if (m0_if.gnt || m1_if.gnt) begin
        if (gnt_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL gnt_unexpected: got m0_gnt=%0d m1_gnt=%0d, expected no grant (t=%0t)",
                   m0_if.gnt, m1_if.gnt, $time);
        end else begin
          e = gnt_q.pop_front();
          chk("gnt_port", {30'd0, m1_if.gnt, m0_if.gnt}, (e.port == 1) ? 32'd2 : 32'd1);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
          chk("mem_be", {28'd0, mem_be}, e.we ? {28'd0, e.be} : 32'hF);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          $display("txn grant port%0d %s addr=0x%08h be=%b wdata=0x%08h",
                   e.port, e.we ? "WR" : "RD", e.addr, e.be, e.wdata);
        end
        gnt_log.push_back(m1_if.gnt ? 1 : 0);
      end else begin
        if (gnt_q.size() != 0) begin
          void'(gnt_q.pop_front());
          n_checks++;
          n_err++;
          $display("FAIL gnt_missing: got no grant, expected one (t=%0t)", $time);
        end
        chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
      end

      exp_v = (rd_q.size() > 0) && (rd_q[0].due == cyc);
      if (exp_v || m0_if.rvalid || m1_if.rvalid) begin
        ep = exp_v ? rd_q[0].port : -1;
        chk("m0_rvalid", {31'd0, m0_if.rvalid}, (ep == 0) ? 32'd1 : 32'd0);
        chk("m1_rvalid", {31'd0, m1_if.rvalid}, (ep == 1) ? 32'd1 : 32'd0);
        if (m0_if.rvalid || m1_if.rvalid) rvalid_cnt++;
        if (m0_if.rvalid && mem_we) overlap_cnt++;
        if (exp_v) begin
          r = rd_q.pop_front();
          if (r.port == 0) begin
            chk("m0_rdata", m0_if.rdata, r.data);
            last_rdata0 = m0_if.rdata;
          end else begin
            chk("m1_rdata", m1_if.rdata, r.data);
          end
          $display("txn rdata port%0d data=0x%08h", r.port, r.data);
        end
      end
    end
  end

  task automatic drive(input int p, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.be = be; m0_if.addr = addr; m0_if.wdata = wdata;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.be = be; m1_if.addr = addr; m1_if.wdata = wdata;
    end
  endtask

  // Present one request, wait (bounded) for its gnt, optionally hold req through
  // the gnt cycle, then drop it.
  task automatic do_req(input int p, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    int  waited;
    bit  seen;
    waited = 0;
    @(posedge clk);
    #1;
    drive(p, 1'b1, we, be, addr, wdata);
    do begin
      @(posedge clk);
      #1;
      waited++;
      seen = (p == 1) ? m1_if.gnt : m0_if.gnt;
    end while (!seen && waited < 100);
    n_checks++;
    if (!seen) begin
      n_err++;
      $display("FAIL gnt_timeout: port%0d got no gnt within 100 cycles, expected one", p);
    end
    if (hold) begin
      @(posedge clk);
      #1;
    end
    drive(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m0_gnt"},    {31'd0, m0_if.gnt}, 32'd0);
    chk({tag, "_m1_gnt"},    {31'd0, m1_if.gnt}, 32'd0);
    chk({tag, "_m0_rvalid"}, {31'd0, m0_if.rvalid}, 32'd0);
    chk({tag, "_m1_rvalid"}, {31'd0, m1_if.rvalid}, 32'd0);
    chk({tag, "_mem_we"},    {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_be"},    {28'd0, mem_be}, 32'd0);
    chk({tag, "_mem_addr"},  mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    resetn   = 1'b0;
    ram_load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ram_load = 1'b0;
    chk_reset_outputs("rst");
    resetn = 1'b1;

    // m0 read of 0x10 returns the preloaded word.
    do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_rdata_0x10", last_rdata0, 32'hDEADBEEF);

    // m1 partial write of 0x20, then m0 reads back the merged word.
    do_req(1, 1'b1, 4'b0011, 32'h20, 32'h1234ABCD, 1'b0);
    do_req(0, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_rdata_low_half", {16'd0, last_rdata0[15:0]}, 32'h0000ABCD);
    chk("t2_rdata_high_half", {16'd0, last_rdata0[31:16]}, 32'h000055AA);

    // Repeated contention: both request in the same cycle.
    for (int r = 0; r < 4; r++) begin
      base = gnt_log.size();
      fork
        do_req(0, 1'b1, 4'hF, 32'h30, $urandom, 1'b0);
        do_req(1, 1'b1, 4'hF, 32'h34, $urandom, 1'b0);
      join
      repeat (2) @(posedge clk);
      #1;
      chk("t3_two_grants", gnt_log.size() - base, 32'd2);
`ifdef DMEM_ARB_RR_EN
      if (gnt_log.size() >= base + 2)
        chk("t3_rr_alternate", (gnt_log[base] != gnt_log[base + 1]) ? 32'd1 : 32'd0, 32'd1);
      if (r > 0 && gnt_log.size() >= base + 1)
        chk("t3_rr_alternate_prev", (gnt_log[base] != gnt_log[base - 1]) ? 32'd1 : 32'd0, 32'd1);
`else
      if (gnt_log.size() >= base + 2) begin
        chk("t3_first_winner", gnt_log[base], 32'd0);
        chk("t3_second_winner", gnt_log[base + 1], 32'd1);
      end
`endif
    end

    // Request held through its gnt cycle gets exactly one grant.
    base = gnt_log.size();
    do_req(0, 1'b0, 4'h0, 32'h24, 32'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_single_gnt", gnt_log.size() - base, 32'd1);

    // m0 read followed by m1 write one cycle later: rvalid lines up with the write.
    base = overlap_cnt;
    fork
      do_req(0, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
      begin
        @(posedge clk);
        do_req(1, 1'b1, 4'hF, 32'h44, 32'hCAFEF00D, 1'b0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("t5_rvalid_with_write", overlap_cnt - base, 32'd1);

    // Randomized traffic from both masters.
    fork
      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_req(0, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
               32'($urandom_range(0, NW - 1) * 4), $urandom, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_req(1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
               32'($urandom_range(0, NW - 1) * 4), $urandom, 1'($urandom_range(0, 1)));
      end
    join
    repeat (4) @(posedge clk);

    // Reset asserted while a read is in flight: outputs clear at once, no rvalid later.
    do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    base = rvalid_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("t7_no_rvalid_after_reset", rvalid_cnt - base, 32'd0);

    chk("gnt_q_drained", gnt_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data block RAM between the CPU load/store port (port 0) and a second bus master (port 1: program loader or peripheral DMA). It registers the winning request onto the RAM port, tracks the single outstanding read, and returns read data with a valid strobe to the owning master. It sits between the core's data-memory signals and the block RAM instance in the top level.

## Interface
Parameters:
- AW, 32, address width (byte address, word-aligned accesses)
- DW, 32, data width; byte-enable width is DW/8

Ports:
- clk  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  request; held with fields stable until gnt
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_be, m1_be  in  DW/8  byte enables (writes); ignored for reads
- m0_addr, m1_addr  in  AW  byte address
- m0_wdata, m1_wdata  in  DW  write data
- m0_gnt, m1_gnt  out  1  one-cycle pulse: request accepted
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse: read data valid
- m0_rdata, m1_rdata  out  DW  read data; meaningful only with rvalid
- mem_addr  out  AW  RAM address (registered)
- mem_be  out  DW/8  RAM byte enables (registered; all-ones on reads)
- mem_we  out  1  RAM write strobe (registered)
- mem_wdata  out  DW  RAM write data (registered)
- mem_rdata  in  DW  RAM read data, valid one cycle after address sampled

## Operation
- FSM states: IDLE (no access on RAM port), ISSUE (access registered on mem_*).
- Each cycle, eligible requesters = reqs whose own gnt is not currently high. If any eligible: pick winner, register its addr/be/we/wdata onto mem_*, pulse its gnt next cycle, go/stay ISSUE. Else go IDLE with mem_we=0.
- Arbitration default: fixed priority, port 0 wins.
- Master must drop req or present a new request in the cycle after gnt; a req still high in the gnt cycle is ignored (not re-granted).
- Reads: on ISSUE of a read, set rd_pending and rd_owner. Next cycle pulse rvalid of rd_owner; both mN_rdata are driven from mem_rdata combinationally.
- Writes: no response beyond gnt; mem_we high exactly one cycle per write.
- Unowned port: rvalid low; rdata undefined but driven.

## Timing
- Reset (resetn low, asynchronous): state=IDLE, all gnt/rvalid 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, rd_pending 0, priority pointer = port 0. Pending read in flight is dropped; no rvalid after reset release.
- Latency: req sampled at edge E -> gnt and mem_* valid after E -> RAM samples at E+1 -> rvalid/rdata after E+1 (read latency 2 cycles from first sampled req).
- Throughput: one access per cycle on RAM port when both masters alternate; single master max one access per 2 cycles.
- Simultaneous requests: one winner; loser stays pending and is granted next cycle (loser is eligible since its gnt is low).
- Read followed by write in next cycle: allowed; rvalid of read coincides with write issue.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin; 1-bit pointer to last winner; on contention, the other port wins; pointer updated on every grant.
- Undefined: fixed priority, port 0 always wins contention; pointer logic absent.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, ISSUE), owner typedef (PORT0, PORT1), BE_ALL constant.
- One natural sub-module: dmem_arb_pick (combinational winner select from eligible reqs and pointer).

## Test plan
- Reset: resetn=0 mid-read -> all outputs 0 immediately; after release no rvalid appears.
- m0 read addr 0x10, RAM holds 0xDEADBEEF -> m0_gnt one cycle after req, m0_rvalid with m0_rdata 0xDEADBEEF one cycle later.
- m1 write addr 0x20, be 4'b0011, data 0x1234ABCD -> mem_we one cycle, mem_be 0011; subsequent m0 read of 0x20 returns low half 0xABCD.
- Both req same cycle, fixed mode -> m0 granted first, m1 granted next cycle; RR build with repeated contention -> grants alternate 0,1,0,1.
- Master holds req through gnt cycle -> no second gnt for same request.
- Back-to-back m0 read, m1 write -> mem port busy two consecutive cycles, m0_rvalid aligned with m1 write issue.
